tribus_ctl: RTL and testbench
=============================

# tribus_ctl

Sequencing controller for the tridirectional open-collector bus transceiver (A/C inverting, B non-inverting). It is the initiator side of the transceiver's control interface: it accepts one transfer request and drives chip select, the 2-bit source select and the three active-low port gates in a glitch-safe order. The order is setup, drive for a programmable settle time, then release. It sits between the bus-master logic and one transceiver, and reports busy, done, abort, error and a transfer count.

## Interface
- SETTLE, 3: number of clock cycles the destination gates are held low; legal range 1..255.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  transfer request; sampled only in IDLE.
- src  input  2  source port: 0=A, 1=B, 2=C, 3=illegal.
- dst  input  3  destination mask {A,B,C}: dst[2]=A, dst[1]=B, dst[0]=C.
- abort  input  1  cancel the transfer in progress.
- cs  output  1  transceiver chip select, active-low.
- s1, s0  output  1 each  transceiver source select; {s1,s0}=src while active, 2'b11 when idle.
- ga, gb, gc  output  1 each  port gates, active-low; low means that port is driven.
- busy  output  1  high in SETUP, DRIVE and RELEASE.
- done  output  1  one-cycle pulse when a transfer completes normally.
- abt  output  1  one-cycle pulse when an aborted transfer returns to IDLE.
- err  output  1  one-cycle pulse when a request is rejected.
- count  output  8  number of completed transfers; wraps from 255 to 0.

## Operation
- States: IDLE, SETUP, DRIVE, RELEASE.
- Reset is asynchronous and takes effect immediately. Reset values: state=IDLE, cs=1, {s1,s0}=2'b11, ga=gb=gc=1, busy=0, done=0, abt=0, err=0, count=0. The same applies when reset is asserted mid-transfer.
- IDLE:
  - cs=1, {s1,s0}=11, all gates=1.
  - When req=1 and the request is legal: latch src and dst, then go to SETUP.
  - A request is illegal if src=3, or dst=0, or dst includes the source's own bit. On an illegal request: err=1 for the next cycle, state stays IDLE, count is unchanged.
- SETUP (one cycle): cs=0, {s1,s0}=latched src, all gates=1.
- DRIVE:
  - cs=0, select held.
  - Gate for each destination bit set in dst = 0; gate for the source port is always 1.
  - A down-counter loaded with SETTLE-1 on entry decrements each cycle. At 0, go to RELEASE.
- RELEASE (one cycle): all gates=1, cs=0, select held. Then go to IDLE.
  - Normal path: done=1 in the first IDLE cycle and count increments.
  - Aborted path: abt=1 instead; count unchanged.
- abort=1 sampled in SETUP or DRIVE forces RELEASE on the next edge. abort in IDLE or RELEASE has no effect.
- Gates and select never change on the same edge. Select changes only while all gates are 1.
- req, src and dst are ignored while busy. Latched values cannot change mid-transfer.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Let E0 be the edge that samples a legal req.
- After E0: SETUP, busy=1. After E1: DRIVE, gates low.
- Gates stay low for exactly SETTLE cycles, through edge E(SETTLE).
- After E(SETTLE+1): RELEASE. After E(SETTLE+2): IDLE, done=1, busy=0.
- Total from E0 to done is SETTLE+2 edges; with SETTLE=3, done is high after E5.
- Back-to-back: req held high is next accepted at the edge following the done cycle's start (E(SETTLE+3)), so there is at least one IDLE cycle between transfers.
- err asserts one cycle after the rejecting edge and never sets busy.
- Abort sampled at edge En in SETUP/DRIVE: RELEASE after En, IDLE with abt=1 after En+1.

## Test plan
- Reset with rst=1 mid-DRIVE (SETTLE=3, src=0, dst=3'b011) -> outputs go to reset values without a clock edge; count=0.
- Legal transfer src=1 (B), dst=3'b101 -> cs=0 and {s1,s0}=01 after E0; ga=gc=0, gb=1 after E1 through E3; gates 1 after E4; done=1 and count=1 after E5.
- Illegal requests: src=3; dst=0; src=2 with dst=3'b001 -> err pulse of one cycle each, busy stays 0, count unchanged.
- abort=1 in the second DRIVE cycle -> RELEASE next, then abt=1, done=0, count unchanged; the next legal req completes normally.
- SETTLE=1 with req held high for 3 transfers -> gates low for 1 cycle each, one IDLE cycle between transfers, count=3; preload 255 transfers and one more -> count wraps to 0.
- Change src and dst during DRIVE -> {s1,s0} and gates keep the latched values.

Source files
------------

// File: rtl/tribus_ctl.sv
// Initiator-side sequencer for a tridirectional open-collector bus transceiver.
// Runs setup -> drive (SETTLE cycles) -> release, with all outputs registered.
module tribus_ctl #(
   parameter int unsigned SETTLE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] src,
   input  logic [2:0] dst,
   input  logic       abort,
   output logic       cs,
   output logic       s1,
   output logic       s0,
   output logic       ga,
   output logic       gb,
   output logic       gc,
   output logic       busy,
   output logic       done,
   output logic       abt,
   output logic       err,
   output logic [7:0] count
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_DRIVE, ST_RELEASE} state_t;

   state_t     r_state, w_next;
   logic [1:0] r_src;
   logic [2:0] r_dst;
   logic [7:0] r_settle;
   logic       r_aborted;
   logic       r_cs, r_busy, r_done, r_abt, r_err;
   logic [1:0] r_sel;
   logic [2:0] r_gates;
   logic [7:0] r_count;

   logic       w_illegal, w_accept;
   logic       w_cs;
   logic [1:0] w_sel;
   logic [2:0] w_gates;

   // Gate-mask bit owned by a source port ({A,B,C} ordering); illegal source owns none.
   function automatic logic [2:0] src_mask(input logic [1:0] s);
      case (s)
         2'd0:    src_mask = 3'b100;
         2'd1:    src_mask = 3'b010;
         2'd2:    src_mask = 3'b001;
         default: src_mask = 3'b000;
      endcase
   endfunction

   assign w_illegal = (src == 2'd3) || (dst == 3'b000) || ((dst & src_mask(src)) != 3'b000);
   assign w_accept  = (r_state == ST_IDLE) && req && !w_illegal;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_SETUP;
         ST_SETUP:   w_next = abort ? ST_RELEASE : ST_DRIVE;
         ST_DRIVE:   if (abort || (r_settle == 8'd0)) w_next = ST_RELEASE;
         ST_RELEASE: w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase

      // Outputs are precomputed from the next state so they can be registered.
      w_cs    = (w_next == ST_IDLE);
      w_sel   = 2'b11;
      w_gates = 3'b111;
      if (w_next != ST_IDLE)
         w_sel = (r_state == ST_IDLE) ? src : r_src;
      if (w_next == ST_DRIVE)
         w_gates = ~(r_dst & ~src_mask(r_src));
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src     <= 2'b00;
         r_dst     <= 3'b000;
         r_settle  <= 8'd0;
         r_aborted <= 1'b0;
         r_cs      <= 1'b1;
         r_sel     <= 2'b11;
         r_gates   <= 3'b111;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_abt     <= 1'b0;
         r_err     <= 1'b0;
         r_count   <= 8'd0;
      end else begin
         if (w_accept) begin
            r_src <= src;
            r_dst <= dst;
         end

         if (r_state == ST_SETUP)
            r_settle <= 8'(SETTLE - 1);
         else if ((r_state == ST_DRIVE) && (r_settle != 8'd0))
            r_settle <= r_settle - 8'd1;

         if (((r_state == ST_SETUP) || (r_state == ST_DRIVE)) && abort)
            r_aborted <= 1'b1;
         else if (r_state == ST_IDLE)
            r_aborted <= 1'b0;

         r_cs    <= w_cs;
         r_sel   <= w_sel;
         r_gates <= w_gates;
         r_busy  <= (w_next != ST_IDLE);
         r_done  <= (r_state == ST_RELEASE) && !r_aborted;
         r_abt   <= (r_state == ST_RELEASE) && r_aborted;
         r_err   <= (r_state == ST_IDLE) && req && w_illegal;

         if ((r_state == ST_RELEASE) && !r_aborted)
            r_count <= r_count + 8'd1;
      end
   end

   assign cs    = r_cs;
   assign s1    = r_sel[1];
   assign s0    = r_sel[0];
   assign ga    = r_gates[2];
   assign gb    = r_gates[1];
   assign gc    = r_gates[0];
   assign busy  = r_busy;
   assign done  = r_done;
   assign abt   = r_abt;
   assign err   = r_err;
   assign count = r_count;

endmodule

// File: tb/tb_tribus_ctl.sv
// Directed bench for tribus_ctl: one instance with SETTLE=3, one with SETTLE=1.
module tb_tribus_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req, abort;
   logic [1:0] src;
   logic [2:0] dst;
   logic       cs, s1, s0, ga, gb, gc, busy, done, abt, err;
   logic [7:0] count;

   logic       req1, abort1;
   logic [1:0] src1;
   logic [2:0] dst1;
   logic       cs1, s11, s01, ga1, gb1, gc1, busy1, done1, abt1, err1;
   logic [7:0] count1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tribus_ctl #(.SETTLE(3)) u_dut (
      .clk(clk), .rst(rst), .req(req), .src(src), .dst(dst), .abort(abort),
      .cs(cs), .s1(s1), .s0(s0), .ga(ga), .gb(gb), .gc(gc),
      .busy(busy), .done(done), .abt(abt), .err(err), .count(count)
   );

   tribus_ctl #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .src(src1), .dst(dst1), .abort(abort1),
      .cs(cs1), .s1(s11), .s0(s01), .ga(ga1), .gb(gb1), .gc(gc1),
      .busy(busy1), .done(done1), .abt(abt1), .err(err1), .count(count1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full normal transfer from an idle start; g = expected {ga,gb,gc} in DRIVE.
   task automatic xfer(input string tag, input logic [1:0] s, input logic [2:0] d,
                       input logic [2:0] g, input logic [7:0] c);
      src = s; dst = d; req = 1'b1;
      tick();
      check({tag, " setup cs"}, cs, 0);
      check({tag, " setup sel"}, {s1, s0}, s);
      check({tag, " setup busy"}, busy, 1);
      check({tag, " setup gates"}, {ga, gb, gc}, 3'b111);
      req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check($sformatf("%s drive%0d gates", tag, i), {ga, gb, gc}, g);
         check($sformatf("%s drive%0d cs", tag, i), cs, 0);
      end
      tick();
      check({tag, " release gates"}, {ga, gb, gc}, 3'b111);
      check({tag, " release busy"}, busy, 1);
      tick();
      check({tag, " done"}, done, 1);
      check({tag, " count"}, count, c);
      check({tag, " idle busy"}, busy, 0);
      check({tag, " idle cs"}, cs, 1);
      check({tag, " idle sel"}, {s1, s0}, 2'b11);
      tick();
      check({tag, " done pulse"}, done, 0);
   endtask

   task automatic reject(input string tag, input logic [1:0] s, input logic [2:0] d);
      src = s; dst = d; req = 1'b1;
      tick();
      req = 1'b0;
      check({tag, " err"}, err, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " cs"}, cs, 1);
      tick();
      check({tag, " err pulse"}, err, 0);
      check({tag, " count"}, count, 1);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; src = 2'd0; dst = 3'd0; abort = 1'b0;
      req1 = 1'b0; src1 = 2'd0; dst1 = 3'd0; abort1 = 1'b0;
      tick(); tick();
      check("rst cs", cs, 1);
      check("rst sel", {s1, s0}, 2'b11);
      check("rst gates", {ga, gb, gc}, 3'b111);
      check("rst flags", {busy, done, abt, err}, 4'b0000);
      check("rst count", count, 0);
      rst = 1'b0;
      tick();

      xfer("legal B->AC", 2'd1, 3'b101, 3'b010, 8'd1);

      reject("ill src3", 2'd3, 3'b100);
      reject("ill dst0", 2'd0, 3'b000);
      reject("ill self", 2'd2, 3'b001);

      // Abort sampled at the edge ending the second DRIVE cycle.
      src = 2'd0; dst = 3'b011; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      check("abt drive1 gates", {ga, gb, gc}, 3'b100);
      tick();
      check("abt drive2 gates", {ga, gb, gc}, 3'b100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abt release gates", {ga, gb, gc}, 3'b111);
      check("abt release busy", busy, 1);
      check("abt release cs", cs, 0);
      tick();
      check("abt pulse", abt, 1);
      check("abt no done", done, 0);
      check("abt count", count, 1);
      check("abt busy", busy, 0);
      tick();
      check("abt pulse end", abt, 0);
      xfer("post-abort", 2'd0, 3'b011, 3'b100, 8'd2);

      // Inputs changed mid-transfer must not disturb latched select/gates.
      src = 2'd2; dst = 3'b110; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      check("chg drive1 gates", {ga, gb, gc}, 3'b001);
      src = 2'd0; dst = 3'b001;
      for (int i = 2; i <= 3; i++) begin
         tick();
         check($sformatf("chg drive%0d gates", i), {ga, gb, gc}, 3'b001);
         check($sformatf("chg drive%0d sel", i), {s1, s0}, 2'b10);
      end
      tick();
      check("chg release sel", {s1, s0}, 2'b10);
      tick();
      check("chg done", done, 1);
      check("chg count", count, 3);
      tick();

      // Asynchronous reset in the middle of DRIVE, away from any clock edge.
      src = 2'd0; dst = 3'b011; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      check("mid drive gates", {ga, gb, gc}, 3'b100);
      #2 rst = 1'b1;
      #1;
      check("async rst cs", cs, 1);
      check("async rst sel", {s1, s0}, 2'b11);
      check("async rst gates", {ga, gb, gc}, 3'b111);
      check("async rst flags", {busy, done, abt, err}, 4'b0000);
      check("async rst count", count, 0);
      tick();
      rst = 1'b0;
      tick();

      // SETTLE=1, req held high: each 4-edge period has 1 gated and 1 idle cycle.
      src1 = 2'd1; dst1 = 3'b100; req1 = 1'b1;
      tick();
      check("s1 setup busy", busy1, 1);
      for (int t = 1; t <= 256; t++) begin
         int n_low, n_idle;
         n_low = 0; n_idle = 0;
         for (int k = 0; k < 4; k++) begin
            tick();
            if ({ga1, gb1, gc1} == 3'b011) n_low++;
            if (!busy1) n_idle++;
         end
         if (t <= 3) begin
            check($sformatf("s1 xfer%0d gated cycles", t), n_low, 1);
            check($sformatf("s1 xfer%0d idle cycles", t), n_idle, 1);
         end
         if (t == 3)   check("s1 count 3", count1, 3);
         if (t == 255) check("s1 count 255", count1, 255);
         if (t == 256) check("s1 count wrap", count1, 0);
      end
      req1 = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
